// File: rtl/vt_pkg.sv
// vt_pkg: shared states, control codes and screen geometry for the text output engine
package vt_pkg;
  typedef enum logic [2:0] {IDLE, PUT, SCR_RD, SCR_WR, CLR} state_t;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] DEL   = 8'h7F;
  localparam logic [7:0] BLANK = 8'h20;
  localparam int COLS    = 80;
  localparam int TOP_ROW = 1;
  localparam int ROWS_S  = 24;
  localparam int ROWS_L  = 38;
  function automatic logic [12:0] rc_addr(input logic [5:0] r, input logic [6:0] c);
    return 13'(r) * 13'(COLS) + 13'(c);
  endfunction
endpackage

// File: rtl/vt_textout_if.sv
// vt_textout_if: Wishbone bus between the text engine and the video RAM port
interface vt_textout_if;
  logic [15:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [1:0]  wb_sel_o;
  logic        wb_ack_i;
  modport master(output wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
                 input wb_dat_i, wb_ack_i);
  modport slave(input wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
                output wb_dat_i, wb_ack_i);
endinterface

// File: rtl/vt_wb_master.sv
// vt_wb_master: single-transaction Wishbone engine, holds stb until ack and idles between cycles
module vt_wb_master (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        req,
  input  logic        we,
  input  logic [12:0] adr,
  input  logic [15:0] dat,
  input  logic [1:0]  sel,
  output logic        done,
  output logic [15:0] rdata,
  vt_textout_if.master bus
);
  logic        cyc, we_q;
  logic [12:0] adr_q;
  logic [15:0] dat_q;
  logic [1:0]  sel_q;
  assign bus.wb_cyc_o = cyc;
  assign bus.wb_stb_o = cyc;
  assign bus.wb_we_o  = we_q;
  assign bus.wb_adr_o = {3'b000, adr_q};
  assign bus.wb_dat_o = dat_q;
  assign bus.wb_sel_o = sel_q;
  // launch on req, drop on the ack edge; done blocks a relaunch while the requester moves on
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      cyc   <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      done  <= 1'b0;
      rdata <= '0;
    end else begin
      done <= 1'b0;
      if (cyc && bus.wb_ack_i) begin
        cyc  <= 1'b0;
        done <= 1'b1;
        if (!we_q) rdata <= bus.wb_dat_i;
      end else if (!cyc && req && !done) begin
        cyc   <= 1'b1;
        we_q  <= we;
        adr_q <= adr;
        dat_q <= dat;
        sel_q <= sel;
      end
    end
  end
endmodule

// File: rtl/vt_textout.sv
// vt_textout: terminal character engine writing glyphs, scrolling and clearing video RAM
module vt_textout import vt_pkg::*; (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [7:0]  ch_i,
  input  logic        ch_valid_i,
  output logic        ch_ready_o,
  input  logic        lmode,
  output logic [12:0] cursor,
  output logic        busy_o,
  vt_textout_if.master wb
);
  state_t      state, state_n;
  logic [5:0]  row, row_n, last, last_n, ln;
  logic [6:0]  col, col_n;
  logic [7:0]  ch, ch_n;
  logic        pend, pend_n, home, home_n, accept, adv, req, we, done;
  logic [12:0] src, src_n, dst, dst_n, pos, lim, adr;
  logic [15:0] dat, rdata;
  logic [1:0]  sel;
  assign ln         = 6'(TOP_ROW) + (lmode ? 6'(ROWS_L - 1) : 6'(ROWS_S - 1));
  assign pos        = rc_addr(row, col);
  assign lim        = rc_addr(last + 6'd1, 7'd0);
  assign ch_ready_o = wb_rst_ni && state == IDLE && !pend;
  assign busy_o     = state != IDLE || pend;
  assign accept     = ch_valid_i && ch_ready_o;
  vt_wb_master u_wbm (
    .wb_clk_i (wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .req      (req),
    .we       (we),
    .adr      (adr),
    .dat      (dat),
    .sel      (sel),
    .done     (done),
    .rdata    (rdata),
    .bus      (wb)
  );
  // state, cursor position and sequence pointers
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state  <= IDLE;
      row    <= 6'(TOP_ROW);
      col    <= '0;
      ch     <= '0;
      pend   <= 1'b0;
      home   <= 1'b0;
      last   <= 6'(TOP_ROW + ROWS_S - 1);
      src    <= '0;
      dst    <= '0;
      cursor <= 13'(TOP_ROW * COLS);
    end else begin
      state  <= state_n;
      row    <= row_n;
      col    <= col_n;
      ch     <= ch_n;
      pend   <= pend_n;
      home   <= home_n;
      last   <= last_n;
      src    <= src_n;
      dst    <= dst_n;
      cursor <= pos;
    end
  end
  // decode captured byte, sequence glyph write, scroll copy and clear
  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    ch_n    = ch;
    pend_n  = pend;
    home_n  = home;
    last_n  = last;
    src_n   = src;
    dst_n   = dst;
    req     = 1'b0;
    we      = 1'b1;
    adr     = pos;
    dat     = {ch, ch};
    sel     = pos[0] ? 2'b10 : 2'b01;
    adv     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          ch_n   = ch_i;
          pend_n = 1'b1;
          last_n = ln;
          row_n  = row > ln ? ln : row;
        end else if (pend) begin
          pend_n = 1'b0;
          if (ch == CR) col_n = 7'd0;
          else if (ch == LF) adv = 1'b1;
          else if (ch == BS) col_n = col != 7'd0 ? col - 7'd1 : col;
          else if (ch == FF) begin
            state_n = CLR;
            dst_n   = 13'(TOP_ROW * COLS);
            home_n  = 1'b1;
          end else if (ch >= 8'h20 && ch != DEL) state_n = PUT;
        end
      end
      PUT: begin
        req = 1'b1;
        if (done) begin
          state_n = IDLE;
          col_n   = col < 7'(COLS - 1) ? col + 7'd1 : 7'd0;
          adv     = col == 7'(COLS - 1);
        end
      end
      SCR_RD: begin
        req = 1'b1;
        we  = 1'b0;
        adr = src;
        if (done) state_n = SCR_WR;
      end
      SCR_WR: begin
        req = 1'b1;
        adr = src - 13'(COLS);
        dat = rdata;
        sel = 2'b11;
        if (done) begin
          state_n = src + 13'd2 == lim ? CLR : SCR_RD;
          src_n   = src + 13'd2;
          dst_n   = lim - 13'(COLS);
          home_n  = 1'b0;
        end
      end
      CLR: begin
        req = 1'b1;
        adr = dst;
        dat = {BLANK, BLANK};
        sel = 2'b11;
        if (done) begin
          dst_n = dst + 13'd2;
          if (dst + 13'd2 == lim) begin
            state_n = IDLE;
            row_n   = home ? 6'(TOP_ROW) : row;
            col_n   = home ? 7'd0 : col;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (adv) begin
      row_n   = row < last ? row + 6'd1 : row;
      state_n = row < last ? IDLE : SCR_RD;
      src_n   = 13'((TOP_ROW + 1) * COLS);
    end
  end
endmodule

// File: tb/tb_vt_textout.sv
// tb_vt_textout: directed checks of glyph writes, control codes, scroll, clear and reset
module tb_vt_textout;
  logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, lmode = 1'b0;
  logic [7:0]  ch = 8'h00;
  logic        ready, busy;
  logic [12:0] cursor;
  int          nvec = 0, nerr = 0;
  vt_textout_if bus();
  vt_textout dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .ch_i      (ch),
    .ch_valid_i(valid),
    .ch_ready_o(ready),
    .lmode     (lmode),
    .cursor    (cursor),
    .busy_o    (busy),
    .wb        (bus)
  );
  always #5 clk = ~clk;

  logic [15:0] mem [4096];
  logic        ack = 1'b0, fill = 1'b0, clr = 1'b0, sp = 1'b0, ap = 1'b0;
  logic [15:0] rd = 16'h0;
  int          dly = 0, cnt = 0, wr_cnt = 0, rd_cnt = 0, blank_cnt = 0, svc_hits = 0, viol = 0, rbusy = 0;
  logic [15:0] min_wa = 16'hFFFF, max_wa = 16'h0, min_ra = 16'hFFFF, max_ra = 16'h0;
  logic [15:0] last_adr = 16'h0, last_dat = 16'h0;
  logic [1:0]  last_sel = 2'b00;
  assign bus.wb_ack_i = ack;
  assign bus.wb_dat_i = rd;

  // video RAM model: acks after dly wait cycles, one-cycle ack pulse
  always @(posedge clk) begin
    if (fill) for (int i = 0; i < 4096; i++) mem[i] <= 16'(i) ^ 16'h5A00;
    if (clr) begin
      wr_cnt <= 0; rd_cnt <= 0; blank_cnt <= 0;
      min_wa <= 16'hFFFF; max_wa <= 16'h0; min_ra <= 16'hFFFF; max_ra <= 16'h0;
    end
    if (ack) begin
      ack <= 1'b0;
      cnt <= 0;
    end else if (bus.wb_cyc_o && bus.wb_stb_o) begin
      if (cnt >= dly) begin
        ack <= 1'b1;
        if (bus.wb_adr_o < 16'd80) svc_hits <= svc_hits + 1;
        if (bus.wb_we_o) begin
          if (bus.wb_sel_o[0]) mem[bus.wb_adr_o[12:1]][7:0] <= bus.wb_dat_o[7:0];
          if (bus.wb_sel_o[1]) mem[bus.wb_adr_o[12:1]][15:8] <= bus.wb_dat_o[15:8];
          wr_cnt    <= wr_cnt + 1;
          blank_cnt <= blank_cnt + int'(bus.wb_dat_o == 16'h2020);
          last_adr  <= bus.wb_adr_o;
          last_dat  <= bus.wb_dat_o;
          last_sel  <= bus.wb_sel_o;
          min_wa    <= bus.wb_adr_o < min_wa ? bus.wb_adr_o : min_wa;
          max_wa    <= bus.wb_adr_o > max_wa ? bus.wb_adr_o : max_wa;
        end else begin
          rd     <= mem[bus.wb_adr_o[12:1]];
          rd_cnt <= rd_cnt + 1;
          min_ra <= bus.wb_adr_o < min_ra ? bus.wb_adr_o : min_ra;
          max_ra <= bus.wb_adr_o > max_ra ? bus.wb_adr_o : max_ra;
        end
      end else cnt <= cnt + 1;
    end else cnt <= 0;
  end

  // protocol watch: stb may only fall after ack, and must stay low the cycle after ack
  always @(negedge clk) begin
    if (rst_n && sp && !bus.wb_stb_o && !ap) viol <= viol + 1;
    if (rst_n && ap && bus.wb_stb_o) viol <= viol + 1;
    if (busy && ready) rbusy <= rbusy + 1;
    sp <= bus.wb_stb_o;
    ap <= ack;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_ready(input int lim);
    int n = 0;
    while (!ready && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(ready), 1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready(200);
    ch = b;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic put(input logic [7:0] b);
    send(b);
    wait_ready(20000);
    @(negedge clk);
  endtask

  task automatic clear_stats();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int n;
    fill = 1'b1;
    repeat (3) @(negedge clk);
    fill = 1'b0;
    clear_stats();
    check("rst_cyc", 32'(bus.wb_cyc_o), 0);
    check("rst_stb", 32'(bus.wb_stb_o), 0);
    check("rst_adr", 32'(bus.wb_adr_o), 0);
    check("rst_sel", 32'(bus.wb_sel_o), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cursor", 32'(cursor), 80);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(ready), 1);

    put(8'h41);
    check("A_writes", wr_cnt, 1);
    check("A_adr", 32'(last_adr), 80);
    check("A_sel", 32'(last_sel), 1);
    check("A_dat", 32'(last_dat), 32'h4141);
    check("A_cursor", 32'(cursor), 81);
    put(8'h42);
    check("B_adr", 32'(last_adr), 81);
    check("B_sel", 32'(last_sel), 2);
    check("B_dat", 32'(last_dat), 32'h4242);
    check("B_cursor", 32'(cursor), 82);
    check("B_mem", 32'(mem[40]), 32'h4241);

    put(8'h08);
    check("bs_cursor", 32'(cursor), 81);
    put(8'h0D);
    check("cr_cursor", 32'(cursor), 80);
    put(8'h08);
    check("bs_col0_cursor", 32'(cursor), 80);
    put(8'h07);
    put(8'h7F);
    check("ignored_cursor", 32'(cursor), 80);
    check("ctl_no_bus", wr_cnt, 2);

    for (int i = 0; i < 80; i++) put(8'(8'h61 + i % 26));
    check("row_last_adr", 32'(last_adr), 159);
    check("row_last_sel", 32'(last_sel), 2);
    check("row_last_dat", 32'(last_dat), 32'h6262);
    check("row_wrap_cursor", 32'(cursor), 160);
    check("row_writes", wr_cnt, 82);

    for (int i = 0; i < 22; i++) put(8'h0A);
    check("lf_cursor", 32'(cursor), 1920);
    put(8'h76); put(8'h77); put(8'h78); put(8'h79); put(8'hFF);
    check("row24_cursor", 32'(cursor), 1925);

    clear_stats();
    put(8'h0A);
    check("scr_reads", rd_cnt, 920);
    check("scr_writes", wr_cnt, 960);
    check("scr_blanks", blank_cnt, 40);
    check("scr_min_ra", 32'(min_ra), 160);
    check("scr_max_ra", 32'(max_ra), 1998);
    check("scr_min_wa", 32'(min_wa), 80);
    check("scr_max_wa", 32'(max_wa), 1998);
    check("scr_cursor", 32'(cursor), 1925);
    check("scr_mem40", 32'(mem[40]), 32'h5A50);
    check("scr_mem920", 32'(mem[920]), 32'h7776);
    check("scr_mem921", 32'(mem[921]), 32'h7978);
    check("scr_mem922", 32'(mem[922]), 32'h59FF);
    check("scr_mem959", 32'(mem[959]), 32'h59E7);
    check("scr_mem999", 32'(mem[999]), 32'h2020);
    check("ready_while_busy", rbusy, 0);

    lmode = 1'b1;
    clear_stats();
    put(8'h0C);
    check("ff_writes", wr_cnt, 1520);
    check("ff_blanks", blank_cnt, 1520);
    check("ff_reads", rd_cnt, 0);
    check("ff_min_wa", 32'(min_wa), 80);
    check("ff_max_wa", 32'(max_wa), 3118);
    check("ff_cursor", 32'(cursor), 80);
    check("svc_row_hits", svc_hits, 0);

    for (int i = 0; i < 29; i++) put(8'h0A);
    check("lmode1_cursor", 32'(cursor), 2400);
    lmode = 1'b0;
    put(8'h0D);
    check("clamp_cursor", 32'(cursor), 1920);

    dly = 5;
    clear_stats();
    send(8'h0A);
    n = 0;
    while (rd_cnt < 3 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("dly_scroll_started", 32'(rd_cnt >= 3), 1);
    n = 0;
    while (bus.wb_stb_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (!bus.wb_stb_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("dly_stb_held", 32'(bus.wb_stb_o), 1);
    check("dly_no_ack_yet", 32'(ack), 0);
    check("dly_busy", 32'(busy), 1);
    check("dly_ready", 32'(ready), 0);
    check("bus_protocol", viol, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cyc", 32'(bus.wb_cyc_o), 0);
    check("midrst_stb", 32'(bus.wb_stb_o), 0);
    check("midrst_cursor", 32'(cursor), 80);
    check("midrst_busy", 32'(busy), 0);
    repeat (3) begin
      check("midrst_ready", 32'(ready), 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("release_ready", 32'(ready), 1);
    check("release_stb", 32'(bus.wb_stb_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
